// File: rtl/div_mon_pkg.sv
// div_mon_pkg -- shared types and constants for the divided-clock period monitor.
//   state_e     : monitor FSM states (IDLE, ARM, MEASURE)
//   ERR_CNT_W   : width of the saturating error counter
//   err_sat_inc : saturating increment for the error counter
package div_mon_pkg;

   localparam int unsigned ERR_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } state_e;

   function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/div_mon_edge_det.sv
// div_mon_edge_det -- rising-edge detector for the divided clock under test.
// Optional feature macro: DIV_MON_SYNC_EN adds a two-flop synchronizer (reset to 0)
// in front of the edge detector; every event is then delayed by exactly 2 clk cycles.
// Ports:
//   clk    : sole clock
//   rst    : asynchronous active-low reset
//   div_in : divided-clock level under test
//   rise   : high for one cycle when the (optionally synchronized) level goes 0 -> 1
module div_mon_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic div_in,
   output logic rise
);

   logic div_s;
   logic div_q;

`ifdef DIV_MON_SYNC_EN
   logic sync1_q;
   logic sync2_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= div_in;
         sync2_q <= sync1_q;
      end
   end

   assign div_s = sync2_q;
`else
   // Without the synchronizer div_in must already be synchronous to clk.
   assign div_s = div_in;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q <= 1'b0;
      end else begin
         div_q <= div_s;
      end
   end

   assign rise = div_s & ~div_q;

endmodule

// File: rtl/div_period_monitor.sv
// div_period_monitor -- measures the period (in clk cycles) of a divided clock and
// reports lock when LOCK_N consecutive periods equal exp_period.
// Optional feature macro: DIV_MON_SYNC_EN (input synchronizer, see div_mon_edge_det).
// Parameters:
//   CNT_W  : period counter width
//   LOCK_N : consecutive matching periods required for lock
// Ports:
//   clk, rst     : clock and asynchronous active-low reset
//   enable       : monitor enable; low forces IDLE and drops lock
//   div_in       : divided-clock level under test
//   exp_period   : expected period; 0 and 1 never match
//   period       : last measured period
//   period_valid : one-cycle pulse when period updates
//   locked       : LOCK_N consecutive matching periods seen
//   mismatch     : one-cycle pulse on a non-matching period
//   overflow     : one-cycle pulse when the counter saturates without a rising edge
//   err_cnt      : saturating count of mismatch and overflow events
module div_period_monitor
   import div_mon_pkg::*;
#(
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned LOCK_N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 div_in,
   input  logic [CNT_W-1:0]     exp_period,
   output logic [CNT_W-1:0]     period,
   output logic                 period_valid,
   output logic                 locked,
   output logic                 mismatch,
   output logic                 overflow,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int unsigned MATCH_W = $clog2(LOCK_N + 1);
   localparam logic [MATCH_W-1:0] LockCnt = MATCH_W'(LOCK_N);

   logic rise;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [MATCH_W-1:0]     match_q, match_d;
   logic [CNT_W-1:0]       period_q, period_d;
   logic                   period_valid_q, period_valid_d;
   logic                   locked_q, locked_d;
   logic                   mismatch_q, mismatch_d;
   logic                   overflow_q, overflow_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic                   period_match;
   logic [MATCH_W-1:0]     match_inc;

   div_mon_edge_det u_edge_det (
      .clk    (clk),
      .rst    (rst),
      .div_in (div_in),
      .rise   (rise)
   );

   always_comb begin
      // exp_period of 0 or 1 can never describe a real period, so never match it.
      period_match = (cnt_q == exp_period) && (exp_period > CNT_W'(1));
      match_inc    = (match_q == LockCnt) ? match_q : match_q + MATCH_W'(1);

      state_d        = state_q;
      cnt_d          = cnt_q;
      match_d        = match_q;
      period_d       = period_q;
      period_valid_d = 1'b0;
      locked_d       = locked_q;
      mismatch_d     = 1'b0;
      overflow_d     = 1'b0;
      err_cnt_d      = err_cnt_q;

      // Disable takes priority over any edge seen in the same cycle.
      if (!enable) begin
         state_d  = IDLE;
         match_d  = '0;
         locked_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = ARM;
            end
            ARM: begin
               // First edge only starts the count; a full period is needed to report.
               if (rise) begin
                  cnt_d   = CNT_W'(1);
                  state_d = MEASURE;
               end
            end
            MEASURE: begin
               if (rise) begin
                  period_d       = cnt_q;
                  period_valid_d = 1'b1;
                  cnt_d          = CNT_W'(1);
                  if (period_match) begin
                     match_d  = match_inc;
                     locked_d = (match_inc == LockCnt);
                  end else begin
                     mismatch_d = 1'b1;
                     match_d    = '0;
                     locked_d   = 1'b0;
                     err_cnt_d  = err_sat_inc(err_cnt_q);
                  end
               end else if (cnt_q == {CNT_W{1'b1}}) begin
                  // Counter saturated: abandon this measurement and re-arm.
                  overflow_d = 1'b1;
                  err_cnt_d  = err_sat_inc(err_cnt_q);
                  match_d    = '0;
                  locked_d   = 1'b0;
                  state_d    = ARM;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         match_q        <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         locked_q       <= 1'b0;
         mismatch_q     <= 1'b0;
         overflow_q     <= 1'b0;
         err_cnt_q      <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         match_q        <= match_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         locked_q       <= locked_d;
         mismatch_q     <= mismatch_d;
         overflow_q     <= overflow_d;
         err_cnt_q      <= err_cnt_d;
      end
   end

   assign period       = period_q;
   assign period_valid = period_valid_q;
   assign locked       = locked_q;
   assign mismatch     = mismatch_q;
   assign overflow     = overflow_q;
   assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_div_period_monitor.sv
// tb_div_period_monitor -- directed bench for div_period_monitor.
// A reference model predicts each period report when the matching rising edge is
// driven; reports are queued and compared when period_valid appears.
// A second instance with CNT_W=4 exercises counter overflow and err_cnt saturation.
module tb_div_period_monitor;

   localparam int unsigned LOCK_N = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        div_in;
   logic [15:0] exp_period;
   logic [15:0] period;
   logic        period_valid;
   logic        locked;
   logic        mismatch;
   logic        overflow;
   logic [7:0]  err_cnt;

   logic        div4;
   logic [3:0]  exp4;
   logic [3:0]  period4;
   logic        pv4;
   logic        lk4;
   logic        mm4;
   logic        ov4;
   logic [7:0]  err4;

   always #5 clk = ~clk;

   div_period_monitor #(
      .CNT_W  (16),
      .LOCK_N (LOCK_N)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .div_in       (div_in),
      .exp_period   (exp_period),
      .period       (period),
      .period_valid (period_valid),
      .locked       (locked),
      .mismatch     (mismatch),
      .overflow     (overflow),
      .err_cnt      (err_cnt)
   );

   div_period_monitor #(
      .CNT_W  (4),
      .LOCK_N (LOCK_N)
   ) dut4 (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .div_in       (div4),
      .exp_period   (exp4),
      .period       (period4),
      .period_valid (pv4),
      .locked       (lk4),
      .mismatch     (mm4),
      .overflow     (ov4),
      .err_cnt      (err4)
   );

   typedef struct packed {
      logic [15:0] per;
      logic        mm;
      logic        lk;
   } exp_t;

   exp_t sb[$];

   int   total = 0;
   int   bad   = 0;
   int   vcount = 0;
   int   w_ph  = 0;
   logic exp_ov4 = 1'b0;

   // Reference model state: 0 idle, 1 armed, 2 measuring; times in clk edges.
   int   m_st = 0;
   int   m_t = 0;
   int   m_last = 0;
   int   m_match = 0;
   int   m_err = 0;
   logic m_prev = 1'b0;
   logic m_locked = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_outputs();
      exp_t e;
      if (period_valid) begin
         if (sb.size() == 0) begin
            chk("valid_unexpected", 32'(period_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            vcount++;
            chk("period", 32'(period), 32'(e.per));
            chk("mismatch", 32'(mismatch), 32'(e.mm));
            chk("locked_at_valid", 32'(locked), 32'(e.lk));
         end
      end else begin
         chk("mismatch_no_valid", 32'(mismatch), 32'd0);
      end
      chk("overflow_main", 32'(overflow), 32'd0);
      chk("valid4", 32'(pv4), 32'd0);
      chk("locked4", 32'(lk4), 32'd0);
      chk("mismatch4", 32'(mm4), 32'd0);
      chk("overflow4", 32'(ov4), 32'(exp_ov4));
   endtask

   // Apply one cycle of stimulus, predict its effect, then sample after the edge.
   task automatic step(input logic en, input logic v);
      logic r;
      int   per;
      logic mm;
      enable = en;
      div_in = v;
      r      = v & ~m_prev;
      m_prev = v;
      if (!en) begin
         m_st     = 0;
         m_match  = 0;
         m_locked = 1'b0;
      end else if (m_st == 0) begin
         m_st = 1;
      end else if (m_st == 1) begin
         if (r) begin
            m_st   = 2;
            m_last = m_t;
         end
      end else if (r) begin
         per    = m_t - m_last;
         m_last = m_t;
         mm     = !((per == int'(exp_period)) && (exp_period >= 16'd2));
         if (mm) begin
            m_match  = 0;
            m_locked = 1'b0;
            if (m_err < 255) m_err++;
         end else begin
            if (m_match < LOCK_N) m_match++;
            m_locked = (m_match == LOCK_N);
         end
         sb.push_back('{per: 16'(per), mm: mm, lk: m_locked});
      end
      m_t++;
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   // Square wave of period 2*half cycles; phase continues across calls.
   task automatic wave(input logic en, input int half, input int n);
      for (int i = 0; i < n; i++) begin
         step(en, (w_ph % (2 * half)) >= half);
         w_ph++;
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_period"}, 32'(period), 32'd0);
      chk({tag, "_valid"}, 32'(period_valid), 32'd0);
      chk({tag, "_locked"}, 32'(locked), 32'd0);
      chk({tag, "_mismatch"}, 32'(mismatch), 32'd0);
      chk({tag, "_overflow"}, 32'(overflow), 32'd0);
      chk({tag, "_err"}, 32'(err_cnt), 32'd0);
      chk({tag, "_err4"}, 32'(err4), 32'd0);
   endtask

   task automatic model_reset();
      m_st     = 0;
      m_match  = 0;
      m_err    = 0;
      m_prev   = 1'b0;
      m_locked = 1'b0;
      w_ph     = 0;
      vcount   = 0;
   endtask

   initial begin
      rst        = 1'b0;
      enable     = 1'b0;
      div_in     = 1'b0;
      div4       = 1'b0;
      exp4       = 4'd5;
      exp_period = 16'd2;
      @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      rst = 1'b1;
      model_reset();

      // Toggle every cycle, expect period 2 and lock on the 4th report.
      wave(1'b1, 1, 12);
      chk("a_vcount", 32'(vcount), 32'd5);
      chk("a_locked", 32'(locked), 32'd1);
      chk("a_period", 32'(period), 32'd2);
      chk("a_sb_empty", 32'(sb.size()), 32'd0);

      // Reset mid-measurement while locked: everything reads 0 at once.
      rst = 1'b0;
      #1;
      check_zero("midrst");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
      model_reset();

      // Divide-by-16 waveform, expected 16.
      exp_period = 16'd16;
      wave(1'b1, 8, 96);
      chk("b_vcount", 32'(vcount), 32'd5);
      chk("b_locked", 32'(locked), 32'd1);
      chk("b_period", 32'(period), 32'd16);
      chk("b_err", 32'(err_cnt), 32'd0);

      // Same waveform, expected 8: five mismatching periods.
      exp_period = 16'd8;
      wave(1'b1, 8, 80);
      chk("c_err", 32'(err_cnt), 32'd5);
      chk("c_err_model", 32'(err_cnt), 32'(m_err));
      chk("c_locked", 32'(locked), 32'd0);
      chk("c_period", 32'(period), 32'd16);

      // Relock, then drop enable for 3 cycles.
      exp_period = 16'd16;
      wave(1'b1, 8, 80);
      chk("d_locked", 32'(locked), 32'd1);
      wave(1'b0, 8, 3);
      chk("d_off_locked", 32'(locked), 32'd0);
      chk("d_off_period", 32'(period), 32'd16);
      chk("d_off_err", 32'(err_cnt), 32'd5);
      vcount = 0;
      wave(1'b1, 8, 96);
      chk("d_vcount", 32'(vcount), 32'd5);
      chk("d_relocked", 32'(locked), 32'd1);
      chk("d_err", 32'(err_cnt), 32'd5);

      // CNT_W=4 instance: one rise then 15 idle cycles overflows; repeat to saturate.
      for (int b = 0; b < 260; b++) begin
         for (int k = 0; k < 16; k++) begin
            div4    = (k == 0);
            exp_ov4 = (k == 15);
            step(1'b1, div_in);
            if (b == 0 && k == 15) begin
               chk("e_err4_first", 32'(err4), 32'd1);
               chk("e_period4_held", 32'(period4), 32'd0);
            end
         end
      end
      div4    = 1'b0;
      exp_ov4 = 1'b0;
      step(1'b1, div_in);
      chk("e_err4_sat", 32'(err4), 32'd255);
      chk("e_period4_final", 32'(period4), 32'd0);
      chk("final_sb_empty", 32'(sb.size()), 32'd0);
      chk("final_err", 32'(err_cnt), 32'd5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div_period_monitor.md
DIV_PERIOD_MONITOR -- requirements
Module: div_period_monitor

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, giving the period counter width in bits.
REQ-002 The module SHALL have parameter LOCK_N, default 4, giving the consecutive matching periods needed for lock.
REQ-003 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Port enable  input  1  monitor enable.
REQ-007 Port div_in  input  1  divided-clock level under test.
REQ-008 Port exp_period  input  CNT_W  expected period in clk cycles; values 0 and 1 never match.
REQ-009 Port period  output  CNT_W  last measured period.
REQ-010 Port period_valid  output  1  one-cycle pulse when period updates.
REQ-011 Port locked  output  1  LOCK_N consecutive periods equalled exp_period.
REQ-012 Port mismatch  output  1  one-cycle pulse when a measured period differs from exp_period.
REQ-013 Port overflow  output  1  one-cycle pulse when the counter saturates without a rising edge.
REQ-014 Port err_cnt  output  8  saturating count of mismatch plus overflow events.

Function
REQ-015 The module SHALL register div_in into div_q and define rise = div_in & ~div_q.
REQ-016 The module SHALL implement states IDLE, ARM and MEASURE.
REQ-017 In IDLE with enable=1 the module SHALL go to ARM; with enable=0 in any state it SHALL go to IDLE, clear locked and the match count, and hold period and err_cnt.
REQ-018 In ARM, on rise, the module SHALL load cnt=1 and go to MEASURE, with no period_valid.
REQ-019 In MEASURE, on a cycle without rise, the module SHALL increment cnt.
REQ-020 In MEASURE, on rise, the module SHALL, at that same clock edge, set period=cnt, pulse period_valid, and reload cnt=1.
REQ-021 The resulting period SHALL equal the number of clk cycles between successive rising edges (2 for a toggle-every-cycle input).
REQ-022 On a period update where period equals exp_period, the module SHALL increment the match count, saturating at LOCK_N, and set locked when the count reaches LOCK_N.
REQ-023 On a period update where period differs from exp_period, the module SHALL pulse mismatch, clear locked and the match count, and increment err_cnt.
REQ-024 When cnt reaches all-ones without rise, the module SHALL pulse overflow, increment err_cnt, clear locked and the match count, leave period unchanged, and return to ARM.
REQ-025 err_cnt SHALL saturate at 255 and SHALL be cleared only by reset.
REQ-026 A change of exp_period SHALL take effect at the next period update and SHALL NOT itself clear locked.
REQ-027 If enable falls in the same cycle as rise, the enable rule SHALL win and no period update SHALL occur.

Reset
REQ-028 While rst=0, the module SHALL force state=IDLE, div_q=0, cnt=0, match count=0, period=0, period_valid=0, locked=0, mismatch=0, overflow=0 and err_cnt=0.
REQ-029 Reset asserted mid-MEASURE SHALL abort the measurement with no partial period reported.
REQ-030 After rst deasserts, the first period_valid SHALL occur only after one ARM edge and one complete period.

Configuration
REQ-031 With DIV_MON_SYNC_EN defined, div_in SHALL pass through a two-flop synchronizer (reset to 0) before edge detection, adding exactly 2 cycles of latency to every event while leaving measured periods unchanged.
REQ-032 Without DIV_MON_SYNC_EN, div_in SHALL feed edge detection directly, and div_in must be synchronous to clk.

Structure
REQ-033 A shared package div_mon_pkg SHALL hold the state enum type (IDLE/ARM/MEASURE) and the ERR_CNT_W=8 constant.
REQ-034 Edge detection, including the optional synchronizer, SHALL be one sub-module, div_mon_edge_det, with output rise.

Verification
REQ-035 Scenario: div_in toggling every cycle, exp_period=2 -> period=2 on every period_valid and locked=1 after the 4th period_valid.
REQ-036 Scenario: div_in toggling every 8 cycles (a 4-stage ripple divider output), exp_period=16 -> period=16, locked after 4 periods, and err_cnt=0.
REQ-037 Scenario: same input as REQ-036 with exp_period=8 -> mismatch pulses with each period_valid, locked stays 0, and err_cnt increments by 1 per period.
REQ-038 Scenario: CNT_W=4 with div_in held 0 after one rising edge -> overflow pulse once cnt reaches 15, state returns to ARM, and err_cnt=1.
REQ-039 Scenario: rst pulsed low mid-MEASURE while locked -> all outputs read 0 immediately, and the first period_valid occurs after a full re-arm and one period.
REQ-040 Scenario: enable dropped for 3 cycles while locked -> locked=0, period held, and locking requires 4 new matching periods after re-arm.
